tdc_thermo_decoder: RTL

- Readout end of the carry-chain fine TDC; consumes its registered thermometer word each clock.
- Arms on request and waits for a clean low baseline, then detects the START edge.
- On detection, converts the thermometer code to a binary fine count and pairs it with a coarse cycle count taken since arming.
- Delivers one timestamp per arm over a valid/ready handshake to the ADC sequencing logic.

---
 rtl/tdc_pkg.sv | 26 ++
 rtl/tdc_thermo_popcount.sv | 30 +++
 rtl/tdc_thermo_decoder.sv | 121 ++++++++++++
 3 files changed

// File: rtl/tdc_pkg.sv
// tdc_pkg: shared definitions for the fine-TDC thermometer readout.
//   state_e : readout FSM state encoding.
//   clog2   : constant function used to size the fine count.
package tdc_pkg;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StWaitLow = 3'd1,
        StArmed   = 3'd2,
        StEncode  = 3'd3,
        StOut     = 3'd4
    } state_e;

    // Ceiling log2; clog2(1) = 0, clog2(6) = 3.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/tdc_thermo_popcount.sv
// tdc_thermo_popcount: combinational popcount and bubble check of a thermometer word.
//   i_word   : thermometer word, bit0 is the chain entry.
//   o_count  : number of ones in i_word (0..STAGES).
//   o_bubble : 1 when some 1 sits above a 0, i.e. the word is not 0..01..1.
module tdc_thermo_popcount
    import tdc_pkg::*;
#(
    parameter  int unsigned STAGES = 5,
    localparam int unsigned FINE_W = clog2(STAGES + 1)
) (
    input  logic [STAGES-1:0] i_word,
    output logic [FINE_W-1:0] o_count,
    output logic              o_bubble
);

    always_comb begin
        o_count  = '0;
        o_bubble = 1'b0;
        for (int i = 0; i < STAGES; i++) begin
            o_count = o_count + FINE_W'(i_word[i]);
        end
        // Any 1-above-0 pattern implies an adjacent 1-over-0 pair somewhere.
        for (int i = 1; i < STAGES; i++) begin
            if (i_word[i] && !i_word[i-1]) begin
                o_bubble = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tdc_thermo_decoder.sv
// tdc_thermo_decoder: readout end of the carry-chain fine TDC.
// Arms on request, waits for a zero baseline, detects the START edge, and
// delivers one {coarse, fine} timestamp per arm over valid/ready.
//   i_clock      : system clock (also the fine TDC STOP clock).
//   i_reset      : synchronous active-low reset.
//   i_arm        : one-cycle measurement request, honoured only in idle.
//   i_thermo     : registered thermometer word from the fine TDC.
//   o_ts_valid   : timestamp available; held until i_ts_ready.
//   i_ts_ready   : consumer accepts the timestamp.
//   o_ts_coarse  : cycles from arm acceptance to detection.
//   o_ts_fine    : popcount of the detection word.
//   o_bubble_err : detection word not a contiguous run of ones from bit0.
//   o_timeout    : coarse counter wrapped before detection.
//   o_busy       : high whenever not idle.
module tdc_thermo_decoder
    import tdc_pkg::*;
#(
    parameter  int unsigned STAGES   = 5,
    parameter  int unsigned COARSE_W = 16,
    localparam int unsigned FINE_W   = clog2(STAGES + 1)
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_arm,
    input  logic [STAGES-1:0]   i_thermo,
    output logic                o_ts_valid,
    input  logic                i_ts_ready,
    output logic [COARSE_W-1:0] o_ts_coarse,
    output logic [FINE_W-1:0]   o_ts_fine,
    output logic                o_bubble_err,
    output logic                o_timeout,
    output logic                o_busy
);

    state_e              r_state;
    state_e              w_state_next;
    logic [COARSE_W-1:0] r_count;
    logic [COARSE_W-1:0] r_coarse;
    logic [STAGES-1:0]   r_word;
    logic [FINE_W-1:0]   r_fine;
    logic                r_bubble;
    logic                r_timeout;

    logic [FINE_W-1:0]   w_fine;
    logic                w_bubble;
    logic                w_detect;
    logic                w_count_max;

    assign w_detect    = |i_thermo;
    assign w_count_max = &r_count;

    tdc_thermo_popcount #(
        .STAGES (STAGES)
    ) u_popcount (
        .i_word   (r_word),
        .o_count  (w_fine),
        .o_bubble (w_bubble)
    );

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:    if (i_arm)                     w_state_next = StWaitLow;
            StWaitLow: if (!w_detect)                 w_state_next = StArmed;
            StArmed:   if (w_detect || w_count_max)   w_state_next = StEncode;
            StEncode:                                 w_state_next = StOut;
            StOut:     if (i_ts_ready)                w_state_next = StIdle;
            default:                                  w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_state   <= StIdle;
            r_count   <= '0;
            r_coarse  <= '0;
            r_word    <= '0;
            r_fine    <= '0;
            r_bubble  <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state <= w_state_next;
            unique case (r_state)
                StIdle: begin
                    if (i_arm) begin
                        r_count <= '0;
                    end
                end
                // Stale trigger time still counts toward the coarse value.
                StWaitLow: r_count <= r_count + COARSE_W'(1);
                StArmed: begin
                    r_count <= r_count + COARSE_W'(1);
                    // Detection wins over wrap when both happen together.
                    if (w_detect) begin
                        r_word    <= i_thermo;
                        r_coarse  <= r_count;
                        r_timeout <= 1'b0;
                    end else if (w_count_max) begin
                        r_word    <= '0;
                        r_coarse  <= r_count;
                        r_timeout <= 1'b1;
                    end
                end
                StEncode: begin
                    r_fine   <= w_fine;
                    r_bubble <= w_bubble;
                end
                default: begin
                end
            endcase
        end
    end

    assign o_ts_valid   = (r_state == StOut);
    assign o_busy       = (r_state != StIdle);
    assign o_ts_coarse  = r_coarse;
    assign o_ts_fine    = r_fine;
    assign o_bubble_err = r_bubble;
    assign o_timeout    = r_timeout;

endmodule
